// File: rtl/sx_exu_fpu_seq_if.sv
// ----------------------------------------------------------------------------
// sx_exu_fpu_seq_if
// Bundles every non-clock, non-reset signal of the FP issue/writeback
// sequencer: the decode handshake, the FPU control-block port, the register
// file write port and the pending-destination / error status outputs.
//   master : the sequencer itself
//   slave  : the surrounding pipeline (decode, FPU control, register file)
// ----------------------------------------------------------------------------
interface sx_exu_fpu_seq_if;
    // decode side
    logic        dec_valid;
    logic        dec_ready;
    logic [2:0]  dec_op;
    logic [31:0] dec_rs1;
    logic [31:0] dec_rs2;
    logic [4:0]  dec_rd_addr;
    logic        flush;
    // FPU control block side
    logic [2:0]  fp_p;
    logic [31:0] fpu_rs1;
    logic [31:0] fpu_rs2;
    logic        fpu_cancel;
    logic        fpu_wb_ready;
    logic        fpu_busy;
    logic        fpu_result_ready;
    logic [31:0] fpu_rd;
    // register-file write port
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ack;
    // status
    logic        pend_valid;
    logic [4:0]  pend_addr;
    logic        illegal_op;
    logic        timeout_err;

    modport master (
        input  dec_valid, dec_op, dec_rs1, dec_rs2, dec_rd_addr, flush,
        input  fpu_busy, fpu_result_ready, fpu_rd, wb_ack,
        output dec_ready, fp_p, fpu_rs1, fpu_rs2, fpu_cancel, fpu_wb_ready,
        output wb_valid, wb_addr, wb_data, pend_valid, pend_addr,
        output illegal_op, timeout_err
    );

    modport slave (
        output dec_valid, dec_op, dec_rs1, dec_rs2, dec_rd_addr, flush,
        output fpu_busy, fpu_result_ready, fpu_rd, wb_ack,
        input  dec_ready, fp_p, fpu_rs1, fpu_rs2, fpu_cancel, fpu_wb_ready,
        input  wb_valid, wb_addr, wb_data, pend_valid, pend_addr,
        input  illegal_op, timeout_err
    );
endinterface

// File: rtl/sx_exu_fpu_seq.sv
// ----------------------------------------------------------------------------
// sx_exu_fpu_seq
// Issue/writeback sequencer for the single-precision FPU. Takes one decoded
// fadd/fmul/fdiv from decode, issues it to the FPU control block, collects the
// result and writes it back through a valid/ack register-file port. Publishes
// the outstanding destination register as a one-entry scoreboard.
//
// Ports:
//   clk  - core clock
//   rst  - asynchronous active-high reset
//   bus  - sx_exu_fpu_seq_if.master (decode, FPU, writeback, status groups)
//
// Parameter:
//   TIMEOUT_CYCLES - WAIT-state watchdog limit (>= 2), only meaningful when
//                    the SX_FPU_TIMEOUT_EN macro is defined.
//
// Build option:
//   SX_FPU_TIMEOUT_EN - enables the WAIT watchdog; without it WAIT lasts until
//                       a result or flush arrives and timeout_err is tied 0.
// ----------------------------------------------------------------------------
module sx_exu_fpu_seq #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    sx_exu_fpu_seq_if.master        bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("sx_exu_fpu_seq: TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        cancel_q, cancel_d;
    logic        op_onehot;
    logic        dec_fire;
    logic        illegal;
    logic        timeout_fire;

    assign bus.dec_ready = (state_q == ST_IDLE) & ~bus.flush & ~rst;
    assign dec_fire      = bus.dec_valid & bus.dec_ready;
    assign op_onehot     = (bus.dec_op == 3'b100) | (bus.dec_op == 3'b010) |
                           (bus.dec_op == 3'b001);

`ifdef SX_FPU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // Held at zero outside WAIT so the first WAIT cycle reads 0 and the
    // TIMEOUT_CYCLES-th WAIT cycle reads TIMEOUT_CYCLES-1.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // A flush or a result arriving in the final cycle takes precedence.
    assign timeout_fire = (state_q == ST_WAIT) & ~bus.flush & ~bus.fpu_result_ready &
                          (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_addr_d = rd_addr_q;
        wb_data_d = wb_data_q;
        cancel_d  = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dec_fire) begin
                    if (op_onehot) begin
                        op_d      = bus.dec_op;
                        rs1_d     = bus.dec_rs1;
                        rs2_d     = bus.dec_rs2;
                        rd_addr_d = bus.dec_rd_addr;
                        state_d   = ST_ISSUE;
                    end else begin
                        // Malformed op is consumed and reported, never issued.
                        illegal = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.flush) begin
                    cancel_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (!bus.fpu_busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.flush) begin
                    // Any result arriving with the flush is dropped.
                    cancel_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (bus.fpu_result_ready) begin
                    wb_data_d = bus.fpu_rd;
                    state_d   = ST_WB;
                end else if (timeout_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // WB: flush drops the write without cancelling the FPU,
                // which already handed the result over.
                if (bus.wb_ack || bus.flush) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_addr_q <= '0;
            wb_data_q <= '0;
            cancel_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_addr_q <= rd_addr_d;
            wb_data_q <= wb_data_d;
            cancel_q  <= cancel_d;
        end
    end

    assign bus.fp_p         = (state_q == ST_ISSUE) ? op_q : 3'b000;
    assign bus.fpu_rs1      = rs1_q;
    assign bus.fpu_rs2      = rs2_q;
    // Flush kills are registered (next cycle); the watchdog kill is issued
    // in the expiring WAIT cycle itself.
    assign bus.fpu_cancel   = cancel_q | timeout_fire;
    assign bus.fpu_wb_ready = (state_q == ST_WAIT);
    assign bus.wb_valid     = (state_q == ST_WB);
    assign bus.wb_addr      = rd_addr_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.pend_valid   = (state_q != ST_IDLE);
    assign bus.pend_addr    = rd_addr_q;
    assign bus.illegal_op   = illegal;
    assign bus.timeout_err  = timeout_fire;

endmodule

// File: tb/tb_sx_exu_fpu_seq.sv
module tb_sx_exu_fpu_seq;
    localparam int TB_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sx_exu_fpu_seq_if bus();

    sx_exu_fpu_seq #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] sb_q[$];   // {wb_addr, wb_data} expected per writeback

    // Inputs change at posedge+1, outputs are sampled at posedge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dec_valid = 1'b0; bus.dec_op = 3'b000; bus.dec_rs1 = '0; bus.dec_rs2 = '0;
        bus.dec_rd_addr = '0; bus.flush = 1'b0; bus.fpu_busy = 1'b0;
        bus.fpu_result_ready = 1'b0; bus.fpu_rd = '0; bus.wb_ack = 1'b0;
    endtask

    // Decode handshake in T0; returns at the sample point of T1 (ISSUE).
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
        tick();
        bus.dec_valid = 1'b1; bus.dec_op = op; bus.dec_rs1 = a; bus.dec_rs2 = b; bus.dec_rd_addr = rd;
        #1;
        n_checks++; if (bus.dec_ready !== 1'b1) begin n_fail++; $display("FAIL send_dec_ready: got %0b expected 1", bus.dec_ready); end
        tick();
        bus.dec_valid = 1'b0;
        #1;
    endtask

    // Waits (bounded) for wb_valid, compares against the scoreboard, stalls
    // the ack for ack_delay cycles, then acks and checks dec_ready returns.
    task automatic do_wb(input int ack_delay);
        int n;
        logic [36:0] exp;
        n = 0;
        while (bus.wb_valid !== 1'b1 && n < 20) begin tick(); #1; n++; end
        n_checks++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL wb_valid_wait: got %0b expected 1", bus.wb_valid); return; end
        n_checks++; if (sb_q.size() == 0) begin n_fail++; $display("FAIL sb_empty: got 0 entries expected 1"); return; end
        exp = sb_q.pop_front();
        $display("wb addr=%0d data=%08h (expect addr=%0d data=%08h)", bus.wb_addr, bus.wb_data, exp[36:32], exp[31:0]);
        n_checks++; if (bus.wb_addr !== exp[36:32]) begin n_fail++; $display("FAIL wb_addr: got %0d expected %0d", bus.wb_addr, exp[36:32]); end
        n_checks++; if (bus.wb_data !== exp[31:0]) begin n_fail++; $display("FAIL wb_data: got %08h expected %08h", bus.wb_data, exp[31:0]); end
        for (int i = 0; i < ack_delay; i++) begin
            tick(); #1;
            n_checks++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL stall_wb_valid: got %0b expected 1", bus.wb_valid); end
            n_checks++; if ({bus.wb_addr, bus.wb_data} !== exp) begin n_fail++; $display("FAIL stall_wb_stable: got %09h expected %09h", {bus.wb_addr, bus.wb_data}, exp); end
            n_checks++; if (bus.dec_ready !== 1'b0) begin n_fail++; $display("FAIL stall_dec_ready: got %0b expected 0", bus.dec_ready); end
        end
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        #1;
        n_checks++; if (bus.dec_ready !== 1'b1) begin n_fail++; $display("FAIL post_ack_dec_ready: got %0b expected 1", bus.dec_ready); end
        n_checks++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL post_ack_wb_valid: got %0b expected 0", bus.wb_valid); end
        n_checks++; if (bus.pend_valid !== 1'b0) begin n_fail++; $display("FAIL post_ack_pend_valid: got %0b expected 0", bus.pend_valid); end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        #1;
        n_checks++; if (bus.dec_ready !== 1'b0) begin n_fail++; $display("FAIL rst_dec_ready: got %0b expected 0", bus.dec_ready); end
        n_checks++; if ({bus.fp_p, bus.fpu_cancel, bus.wb_valid, bus.pend_valid, bus.illegal_op, bus.timeout_err} !== 8'h00) begin
            n_fail++; $display("FAIL rst_ctrl: got %02h expected 00", {bus.fp_p, bus.fpu_cancel, bus.wb_valid, bus.pend_valid, bus.illegal_op, bus.timeout_err}); end
        n_checks++; if ({bus.wb_addr, bus.wb_data, bus.pend_addr, bus.fpu_rs1, bus.fpu_rs2} !== '0) begin
            n_fail++; $display("FAIL rst_data: got nonzero data registers expected 0"); end
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (bus.dec_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_dec_ready: got %0b expected 1", bus.dec_ready); end
    endtask

    task automatic test_add();
        send(3'b100, 32'h3F800000, 32'h40000000, 5'd5);
        n_checks++; if (bus.fp_p !== 3'b100) begin n_fail++; $display("FAIL add_fp_p_t1: got %03b expected 100", bus.fp_p); end
        n_checks++; if (bus.pend_valid !== 1'b1 || bus.pend_addr !== 5'd5) begin n_fail++; $display("FAIL add_pend: got %0b/%0d expected 1/5", bus.pend_valid, bus.pend_addr); end
        n_checks++; if (bus.fpu_rs1 !== 32'h3F800000 || bus.fpu_rs2 !== 32'h40000000) begin n_fail++; $display("FAIL add_operands: got %08h/%08h expected 3f800000/40000000", bus.fpu_rs1, bus.fpu_rs2); end
        tick(); #1;
        n_checks++; if (bus.fp_p !== 3'b000) begin n_fail++; $display("FAIL add_fp_p_t2: got %03b expected 000", bus.fp_p); end
        n_checks++; if (bus.fpu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL add_wb_ready: got %0b expected 1", bus.fpu_wb_ready); end
        tick();
        bus.fpu_result_ready = 1'b1; bus.fpu_rd = 32'h40400000;
        sb_q.push_back({5'd5, 32'h40400000});
        #1;
        n_checks++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_wb_early: got %0b expected 0", bus.wb_valid); end
        tick();
        bus.fpu_result_ready = 1'b0;
        #1;
        n_checks++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL add_wb_rise: got %0b expected 1", bus.wb_valid); end
        do_wb(0);
    endtask

    task automatic test_busy();
        bus.fpu_busy = 1'b1;
        send(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd9);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                tick();
                if (k == 3) bus.fpu_busy = 1'b0;
                #1;
            end
            n_checks++; if (bus.fp_p !== 3'b001) begin n_fail++; $display("FAIL busy_fp_p[%0d]: got %03b expected 001", k, bus.fp_p); end
            n_checks++; if (bus.fpu_rs1 !== 32'h12345678 || bus.fpu_rs2 !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL busy_operands[%0d]: got %08h/%08h", k, bus.fpu_rs1, bus.fpu_rs2); end
        end
        tick();
        bus.fpu_result_ready = 1'b1; bus.fpu_rd = 32'hC0A00000;
        sb_q.push_back({5'd9, 32'hC0A00000});
        #1;
        n_checks++; if (bus.fp_p !== 3'b000 || bus.fpu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL busy_wait_entry: got fp_p=%03b wb_ready=%0b expected 000/1", bus.fp_p, bus.fpu_wb_ready); end
        tick();
        bus.fpu_result_ready = 1'b0;
        #1;
        do_wb(0);
    endtask

    task automatic test_flush_wait();
        send(3'b010, 32'h40000000, 32'h40000000, 5'd7);
        tick(); #1;
        n_checks++; if (bus.fpu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL fw_wait1: got %0b expected 1", bus.fpu_wb_ready); end
        tick();
        bus.flush = 1'b1;
        #1;
        n_checks++; if (bus.pend_valid !== 1'b1 || bus.fpu_cancel !== 1'b0) begin n_fail++; $display("FAIL fw_flush_cycle: got pend=%0b cancel=%0b expected 1/0", bus.pend_valid, bus.fpu_cancel); end
        tick();
        bus.flush = 1'b0;
        #1;
        n_checks++; if (bus.fpu_cancel !== 1'b1) begin n_fail++; $display("FAIL fw_cancel: got %0b expected 1", bus.fpu_cancel); end
        n_checks++; if (bus.pend_valid !== 1'b0 || bus.fpu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL fw_idle: got pend=%0b wb_ready=%0b expected 0/0", bus.pend_valid, bus.fpu_wb_ready); end
        tick();
        bus.fpu_result_ready = 1'b1; bus.fpu_rd = 32'hDEADBEEF;
        #1;
        n_checks++; if (bus.fpu_cancel !== 1'b0) begin n_fail++; $display("FAIL fw_cancel_width: got %0b expected 0", bus.fpu_cancel); end
        tick();
        bus.fpu_result_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.wb_valid !== 1'b0 || bus.pend_valid !== 1'b0) begin n_fail++; $display("FAIL fw_stale_result[%0d]: got wb=%0b pend=%0b expected 0/0", i, bus.wb_valid, bus.pend_valid); end
            tick(); #1;
        end
    endtask

    task automatic test_wb_stall();
        send(3'b100, 32'h41200000, 32'h3F000000, 5'd12);
        tick();
        bus.fpu_result_ready = 1'b1; bus.fpu_rd = 32'h41280000;
        sb_q.push_back({5'd12, 32'h41280000});
        #1;
        tick();
        bus.fpu_result_ready = 1'b0;
        #1;
        do_wb(5);
    endtask

    task automatic test_illegal();
        tick();
        bus.dec_valid = 1'b1; bus.dec_op = 3'b011; bus.dec_rd_addr = 5'd20;
        #1;
        n_checks++; if (bus.illegal_op !== 1'b1) begin n_fail++; $display("FAIL ill_pulse: got %0b expected 1", bus.illegal_op); end
        tick();
        bus.dec_valid = 1'b0;
        #1;
        n_checks++; if (bus.illegal_op !== 1'b0) begin n_fail++; $display("FAIL ill_pulse_width: got %0b expected 0", bus.illegal_op); end
        n_checks++; if (bus.pend_valid !== 1'b0 || bus.fp_p !== 3'b000 || bus.dec_ready !== 1'b1) begin
            n_fail++; $display("FAIL ill_stay_idle: got pend=%0b fp_p=%03b ready=%0b expected 0/000/1", bus.pend_valid, bus.fp_p, bus.dec_ready); end
    endtask

    task automatic test_flush_idle();
        tick();
        bus.dec_valid = 1'b1; bus.dec_op = 3'b100; bus.flush = 1'b1;
        #1;
        n_checks++; if (bus.dec_ready !== 1'b0) begin n_fail++; $display("FAIL fi_dec_ready: got %0b expected 0", bus.dec_ready); end
        tick();
        bus.dec_valid = 1'b0; bus.flush = 1'b0;
        #1;
        n_checks++; if (bus.pend_valid !== 1'b0 || bus.fp_p !== 3'b000) begin n_fail++; $display("FAIL fi_not_taken: got pend=%0b fp_p=%03b expected 0/000", bus.pend_valid, bus.fp_p); end
    endtask

    task automatic test_flush_wb();
        // flush alone in WB: write dropped, no cancel
        send(3'b100, 32'h1, 32'h2, 5'd3);
        tick(); bus.fpu_result_ready = 1'b1; bus.fpu_rd = 32'h0BADF00D; #1;
        tick(); bus.fpu_result_ready = 1'b0; #1;
        tick(); bus.flush = 1'b1; #1;
        n_checks++; if (bus.wb_valid !== 1'b1 || bus.pend_valid !== 1'b1) begin n_fail++; $display("FAIL fwb_flush_cycle: got wb=%0b pend=%0b expected 1/1", bus.wb_valid, bus.pend_valid); end
        tick(); bus.flush = 1'b0; #1;
        n_checks++; if (bus.wb_valid !== 1'b0 || bus.fpu_cancel !== 1'b0 || bus.dec_ready !== 1'b1) begin
            n_fail++; $display("FAIL fwb_after: got wb=%0b cancel=%0b ready=%0b expected 0/0/1", bus.wb_valid, bus.fpu_cancel, bus.dec_ready); end
        // flush together with wb_ack: write counts as done
        send(3'b001, 32'h3, 32'h4, 5'd4);
        tick(); bus.fpu_result_ready = 1'b1; bus.fpu_rd = 32'hA5A5A5A5; sb_q.push_back({5'd4, 32'hA5A5A5A5}); #1;
        tick(); bus.fpu_result_ready = 1'b0; #1;
        n_checks++; if (sb_q.size() == 0) begin n_fail++; $display("FAIL fwb_sb_empty: got 0 entries expected 1"); end
        else begin
            logic [36:0] exp;
            exp = sb_q.pop_front();
            $display("wb addr=%0d data=%08h (flush+ack)", bus.wb_addr, bus.wb_data);
            n_checks++; if (bus.wb_valid !== 1'b1 || {bus.wb_addr, bus.wb_data} !== exp) begin
                n_fail++; $display("FAIL fwb_ack_data: got %0b %09h expected 1 %09h", bus.wb_valid, {bus.wb_addr, bus.wb_data}, exp); end
        end
        bus.flush = 1'b1; bus.wb_ack = 1'b1;
        tick(); bus.flush = 1'b0; bus.wb_ack = 1'b0; #1;
        n_checks++; if (bus.wb_valid !== 1'b0 || bus.fpu_cancel !== 1'b0 || bus.dec_ready !== 1'b1) begin
            n_fail++; $display("FAIL fwb_ack_after: got wb=%0b cancel=%0b ready=%0b expected 0/0/1", bus.wb_valid, bus.fpu_cancel, bus.dec_ready); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [2:0]  op;
            logic [4:0]  rd;
            logic [31:0] res;
            op  = 3'b100 >> (i % 3);
            rd  = 5'($urandom_range(1, 31));
            res = $urandom;
            send(op, $urandom, $urandom, rd);
            n_checks++; if (bus.fp_p !== op) begin n_fail++; $display("FAIL b2b_fp_p[%0d]: got %03b expected %03b", i, bus.fp_p, op); end
            tick();
            bus.fpu_result_ready = 1'b1; bus.fpu_rd = res;
            sb_q.push_back({rd, res});
            #1;
            tick();
            bus.fpu_result_ready = 1'b0;
            #1;
            do_wb(i % 2);
        end
    endtask

    task automatic test_reset_mid();
        send(3'b010, 32'h5, 32'h6, 5'd17);
        tick(); #1;
        tick(); rst = 1'b1; #1;
        n_checks++; if (bus.pend_valid !== 1'b0 || bus.fpu_wb_ready !== 1'b0 || bus.dec_ready !== 1'b0) begin
            n_fail++; $display("FAIL rm_async: got pend=%0b wb_ready=%0b ready=%0b expected 0/0/0", bus.pend_valid, bus.fpu_wb_ready, bus.dec_ready); end
        tick(); rst = 1'b0; #1;
        n_checks++; if (bus.fpu_cancel !== 1'b0 || bus.dec_ready !== 1'b1) begin
            n_fail++; $display("FAIL rm_after: got cancel=%0b ready=%0b expected 0/1", bus.fpu_cancel, bus.dec_ready); end
    endtask

    task automatic test_timeout();
        send(3'b001, 32'h7, 32'h8, 5'd21);
`ifdef SX_FPU_TIMEOUT_EN
        for (int w = 1; w <= TB_TIMEOUT; w++) begin
            tick(); #1;
            if (w < TB_TIMEOUT) begin
                n_checks++; if (bus.timeout_err !== 1'b0 || bus.fpu_cancel !== 1'b0) begin n_fail++; $display("FAIL to_early[%0d]: got err=%0b cancel=%0b expected 0/0", w, bus.timeout_err, bus.fpu_cancel); end
            end else begin
                n_checks++; if (bus.timeout_err !== 1'b1 || bus.fpu_cancel !== 1'b1) begin n_fail++; $display("FAIL to_fire: got err=%0b cancel=%0b expected 1/1", bus.timeout_err, bus.fpu_cancel); end
            end
        end
        tick(); #1;
        n_checks++; if (bus.pend_valid !== 1'b0 || bus.timeout_err !== 1'b0 || bus.fpu_cancel !== 1'b0) begin
            n_fail++; $display("FAIL to_idle: got pend=%0b err=%0b cancel=%0b expected 0/0/0", bus.pend_valid, bus.timeout_err, bus.fpu_cancel); end
`else
        for (int w = 1; w <= 3 * TB_TIMEOUT; w++) begin
            tick(); #1;
            n_checks++; if (bus.fpu_wb_ready !== 1'b1 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_stay_wait[%0d]: got wb_ready=%0b err=%0b expected 1/0", w, bus.fpu_wb_ready, bus.timeout_err); end
        end
        tick(); bus.flush = 1'b1; #1;
        tick(); bus.flush = 1'b0; #1;
        n_checks++; if (bus.pend_valid !== 1'b0 || bus.fpu_cancel !== 1'b1) begin
            n_fail++; $display("FAIL to_flush_exit: got pend=%0b cancel=%0b expected 0/1", bus.pend_valid, bus.fpu_cancel); end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_busy();
        test_flush_wait();
        test_wb_stall();
        test_illegal();
        test_flush_idle();
        test_flush_wb();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound on total simulated time.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "simulation time limit reached");
    end

endmodule
